// File: rtl/fpcvt_seq_ctrl_if.sv
// Request/result bundle between the sample capture logic and the sequential
// 12-bit to 8-bit float converter.
interface fpcvt_seq_ctrl_if;
  logic        start;
  logic [11:0] d;
  logic        busy;
  logic        done;
  logic        s;
  logic [2:0]  e;
  logic [3:0]  f;

  modport master (output start, output d, input busy, input done, input s, input e, input f);
  modport slave  (input start, input d, output busy, output done, output s, output e, output f);
endinterface

// File: rtl/fpcvt_seq_ctrl.sv
// Multi-cycle 12-bit two's-complement to S/E3/F4 float converter: magnitude,
// one-bit-per-cycle normalization, then round-half-up with saturation.
module fpcvt_seq_ctrl (
  input  logic              clk,
  input  logic              rst,
  fpcvt_seq_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, ABS, NORM, ROUND, DONE} state_t;

  state_t      state;
  logic [11:0] d_reg;
  logic [10:0] mag;
  logic [2:0]  ec;
  logic [3:0]  frac;
  logic        rb;

  logic [11:0] neg_d;
  logic [11:0] abs_d;

  // abs_d[11] can only be set by 0x800, whose magnitude does not fit in 11 bits.
  assign neg_d = ~d_reg + 12'd1;
  assign abs_d = d_reg[11] ? neg_d : d_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      d_reg    <= '0;
      mag      <= '0;
      ec       <= '0;
      frac     <= '0;
      rb       <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.s    <= 1'b0;
      bus.e    <= '0;
      bus.f    <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            d_reg    <= bus.d;
            state    <= ABS;
            bus.busy <= 1'b1;
          end
        end
        ABS: begin
          mag   <= abs_d[11] ? 11'h7FF : abs_d[10:0];
          ec    <= 3'd7;
          state <= NORM;
        end
        NORM: begin
          if (mag[10] || ec == 3'd0) begin
            frac  <= mag[10:7];
            rb    <= mag[6];
            state <= ROUND;
          end else begin
            mag <= {mag[9:0], 1'b0};
            ec  <= ec - 3'd1;
          end
        end
        ROUND: begin
          bus.s <= d_reg[11];
          if (!rb) begin
            bus.e <= ec;
            bus.f <= frac;
          end else if (frac != 4'hF) begin
            bus.e <= ec;
            bus.f <= frac + 4'd1;
          end else if (ec != 3'd7) begin
            // Significand overflow renormalizes into the next binade.
            bus.e <= ec + 3'd1;
            bus.f <= 4'b1000;
          end else begin
            bus.e <= 3'd7;
            bus.f <= 4'hF;
          end
          bus.done <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpcvt_seq_ctrl.sv
// Randomized and directed checks of fpcvt_seq_ctrl against an arithmetic
// model of the conversion (value rounding and latency).
module tb_fpcvt_seq_ctrl;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  fpcvt_seq_ctrl_if bus ();

  fpcvt_seq_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Result is round-half-up of |d| / 2^E with the smallest E in 0..7 that
  // keeps the significand below 16; latency follows from the shift count.
  function automatic void model(input logic [11:0] din, output int es, output int ee,
                                output int ef, output int lat);
    int v, mag, p, sh, ex, q;
    v   = din[11] ? int'(din) - 4096 : int'(din);
    es  = din[11] ? 1 : 0;
    mag = (v < 0) ? -v : v;
    if (mag > 2047) mag = 2047;
    p = -1;
    for (int i = 0; i < 11; i++)
      if (((mag >> i) & 1) != 0) p = i;
    sh = (p < 0) ? 7 : (((10 - p) > 7) ? 7 : (10 - p));
    ex = 7 - sh;
    q  = (ex > 0) ? ((mag + (1 << (ex - 1))) >> ex) : mag;
    if (q == 16) begin
      ex = ex + 1;
      q  = 8;
    end
    if (ex > 7) begin
      ex = 7;
      q  = 15;
    end
    ee  = ex;
    ef  = q;
    lat = sh + 3;
  endfunction

  task automatic applyStimulus(input logic [11:0] din, input bit noise);
    int  es, ee, ef, lat, n;
    bit  got;
    model(din, es, ee, ef, lat);
    @(negedge clk);
    bus.start = 1'b1;
    bus.d     = din;
    @(posedge clk);
    n   = 0;
    got = 1'b0;
    @(negedge clk);
    checkOutput("busy_after_start", int'(bus.busy), 1);
    while (!got && n < 20) begin
      if (noise) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.d     = 12'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      n++;
      @(negedge clk);
      if (bus.done) got = 1'b1;
    end
    bus.start = 1'b0;
    checkOutput("done_seen", int'(got), 1);
    checkOutput("latency", n, lat);
    checkOutput("busy_in_done", int'(bus.busy), 1);
    checkOutput("s", int'(bus.s), es);
    checkOutput("e", int'(bus.e), ee);
    checkOutput("f", int'(bus.f), ef);
    @(posedge clk);
    @(negedge clk);
    checkOutput("done_pulse_end", int'(bus.done), 0);
    checkOutput("busy_idle", int'(bus.busy), 0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("no_second_run", int'(bus.busy), 0);
    checkOutput("f_hold", int'(bus.f), ef);
  endtask

  logic [11:0] directed [7];

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.d        = '0;
    directed[0] = 12'h000;
    directed[1] = 12'h7FF;
    directed[2] = 12'h800;
    directed[3] = 12'h07D;
    directed[4] = 12'hFF6;
    directed[5] = 12'h001;
    directed[6] = 12'h008;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", int'(bus.busy), 0);
    checkOutput("rst_done", int'(bus.done), 0);
    checkOutput("rst_s", int'(bus.s), 0);
    checkOutput("rst_e", int'(bus.e), 0);
    checkOutput("rst_f", int'(bus.f), 0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) applyStimulus(directed[i], 1'b0);

    // Start re-pulsed with a different sample while the first one is in flight.
    applyStimulus(12'h02C, 1'b1);

    for (int i = 0; i < 40; i++) applyStimulus(12'($urandom), 1'($urandom_range(0, 1)));

    applyStimulus(12'h800, 1'b0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.d     = 12'h001;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_busy", int'(bus.busy), 0);
    checkOutput("abort_done", int'(bus.done), 0);
    checkOutput("abort_s", int'(bus.s), 0);
    checkOutput("abort_e", int'(bus.e), 0);
    checkOutput("abort_f", int'(bus.f), 0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("abort_no_done", int'(bus.done), 0);
    end
    applyStimulus(12'h07D, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
